// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : Multi-cycle MEM-stage access controller that freezes the pipeline
//            while a load/store runs against the data memory.
// Options  : MEM_STAGE_RANGE_CHECK_EN enables the out-of-range address trap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
  parameter int          WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          DEPTH       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_r_req,
  input  logic        mem_w_req,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic        freeze,
  output logic        done,
  output logic [31:0] rd_result,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_cnt_init = 4'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || DEPTH < 1 || BASE_ADDR[1:0] != 2'b00) begin : g_param_check
      $error("mem_stage_ctrl: illegal WAIT_CYCLES, DEPTH or unaligned BASE_ADDR");
    end
  endgenerate

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_is_store;
  logic       w_req;
  logic       w_accept;
  logic       w_last;
  logic       w_blocked;

  assign w_req    = mem_r_req | mem_w_req;
  assign w_accept = (r_state == S_IDLE) && w_req;
  assign w_last   = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef MEM_STAGE_RANGE_CHECK_EN
  localparam logic [32:0] c_range_lo = {1'b0, BASE_ADDR};
  localparam logic [32:0] c_range_hi = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  logic w_out_of_range;
  logic r_blocked;
  logic r_addr_err;

  assign w_out_of_range = ({1'b0, address} < c_range_lo) || ({1'b0, address} >= c_range_hi);

  // The flag travels with the latched access so the FSM timing is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blocked  <= 1'b0;
      r_addr_err <= 1'b0;
    end else if (w_accept) begin
      r_blocked  <= w_out_of_range;
      r_addr_err <= r_addr_err | w_out_of_range;
    end
  end

  assign w_blocked = r_blocked;
  assign addr_err  = r_addr_err;
`else
  assign w_blocked = 1'b0;
  assign addr_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    freeze      = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          freeze      = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = c_cnt_init;
        end
      end
      S_WAIT: begin
        freeze    = 1'b1;
        mem_rd_en = !r_is_store && !w_blocked;
        if (r_cnt == 4'd0) begin
          mem_wr_en   = r_is_store && !w_blocked;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        // Inputs still hold the finished instruction here, so they are ignored.
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Store wins when both requests are raised together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_store <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else if (w_accept) begin
      r_is_store <= mem_w_req;
      mem_addr   <= address & 32'hFFFF_FFFC;
      mem_wdata  <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_result <= 32'd0;
    end else if (w_last && !r_is_store) begin
      rd_result <= w_blocked ? 32'd0 : mem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Directed plus randomized transaction-level checks of mem_stage_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

  localparam int          W     = 4;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r_req, mem_w_req;
  logic [31:0] address, wr_data;
  logic        freeze, done, mem_rd_en, mem_wr_en, addr_err;
  logic [31:0] rd_result, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (BASE),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_r_req(mem_r_req),
    .mem_w_req(mem_w_req),
    .address  (address),
    .wr_data  (wr_data),
    .freeze   (freeze),
    .done     (done),
    .rd_result(rd_result),
    .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .addr_err (addr_err)
  );

  logic [31:0] phys_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rd;
  logic        exp_err;

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) % DEPTH;
  endfunction

  assign mem_rdata = in_range(mem_addr) ? phys_mem[widx(mem_addr)] : 32'hBAD0_BAD0;

  always @(posedge clk)
    if (mem_wr_en && in_range(mem_addr)) phys_mem[widx(mem_addr)] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full access; entered just after a rising edge, leaves requests driven.
  task automatic access(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] d);
    bit          flag;
    bit          ld_eff, st_eff;
    logic [31:0] aa;
`ifdef MEM_STAGE_RANGE_CHECK_EN
    flag = !in_range(a);
`else
    flag = 1'b0;
`endif
    ld_eff = ld && !st && !flag;
    st_eff = st && !flag;
    aa     = {a[31:2], 2'b00};
    mem_r_req = ld; mem_w_req = st; address = a; wr_data = d;
    for (int c = 0; c <= W + 1; c++) begin
      @(negedge clk);
      if (c == 1 && flag) exp_err = 1'b1;
      if (c == W + 1 && ld && !st) exp_rd = flag ? 32'd0 : ref_mem[widx(aa)];
      if (c == W + 1 && st_eff) ref_mem[widx(aa)] = d;
      check("freeze",    {31'd0, freeze},    {31'd0, c <= W});
      check("done",      {31'd0, done},      {31'd0, c == W + 1});
      check("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, ld_eff && c >= 1 && c <= W});
      check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, st_eff && c == W});
      check("addr_err",  {31'd0, addr_err},  {31'd0, exp_err});
      check("rd_result", rd_result, exp_rd);
      if (c >= 1) begin
        check("mem_addr",  mem_addr,  aa);
        check("mem_wdata", mem_wdata, d);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    mem_r_req = 1'b0; mem_w_req = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_freeze", {31'd0, freeze},    32'd0);
      check("idle_done",   {31'd0, done},      32'd0);
      check("idle_wr_en",  {31'd0, mem_wr_en}, 32'd0);
      check("idle_rd_en",  {31'd0, mem_rd_en}, 32'd0);
      check("idle_rd_res", rd_result, exp_rd);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int          kind;
    for (int i = 0; i < DEPTH; i++) begin
      phys_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
      ref_mem[i]  = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    end
    exp_rd = 32'd0; exp_err = 1'b0;
    rst_n = 1'b0; mem_r_req = 1'b0; mem_w_req = 1'b0; address = 32'd0; wr_data = 32'd0;

    // Reset state
    #12;
    check("rst_freeze", {31'd0, freeze},    32'd0);
    check("rst_done",   {31'd0, done},      32'd0);
    check("rst_rd_en",  {31'd0, mem_rd_en}, 32'd0);
    check("rst_wr_en",  {31'd0, mem_wr_en}, 32'd0);
    check("rst_rd_res", rd_result, 32'd0);
    check("rst_addr",   mem_addr,  32'd0);
    check("rst_wdata",  mem_wdata, 32'd0);
    check("rst_err",    {31'd0, addr_err},  32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // Directed: store, load back, store holding rd_result, unaligned, both, back-to-back
    access(1'b0, 1'b1, 32'h404, 32'hDEAD_BEEF); idle(1);
    access(1'b1, 1'b0, 32'h404, 32'h0);         idle(1);
    access(1'b0, 1'b1, 32'h410, 32'h5555_AAAA); idle(1);
    access(1'b1, 1'b0, 32'h407, 32'h0);         idle(1);
    access(1'b1, 1'b1, 32'h420, 32'hCAFE_F00D); idle(1);
    access(1'b1, 1'b0, 32'h420, 32'h0);
    access(1'b0, 1'b1, 32'h430, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h430, 32'h0);         idle(2);

`ifdef MEM_STAGE_RANGE_CHECK_EN
    access(1'b1, 1'b0, 32'h300, 32'h0);         idle(1);
    access(1'b0, 1'b1, 32'h500, 32'hFFFF_0000); idle(1);
    access(1'b1, 1'b0, 32'h404, 32'h0);         idle(1);
`endif

    // Randomized traffic with random gaps (gap 0 = back-to-back)
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 3));
      a    = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
`ifdef MEM_STAGE_RANGE_CHECK_EN
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 32'h3FF));
`endif
      d = $urandom;
      access(kind == 0 || kind == 2 || kind == 3, kind == 1 || kind == 2, a, d);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    // Reset in the middle of a store's WAIT phase
    address = 32'h408; wr_data = 32'h0BAD_0BAD; mem_w_req = 1'b1; mem_r_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0; mem_w_req = 1'b0;
    exp_rd = 32'd0; exp_err = 1'b0;
    #1;
    check("abort_freeze", {31'd0, freeze},    32'd0);
    check("abort_wr_en",  {31'd0, mem_wr_en}, 32'd0);
    check("abort_rd_res", rd_result, 32'd0);
    check("abort_err",    {31'd0, addr_err},  32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_done",  {31'd0, done},      32'd0);
      check("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    access(1'b1, 1'b0, 32'h408, 32'h0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Multi-cycle access controller between the EXE/MEM pipeline register and the data memory.
- Accepts a load or store request from the MEM stage and latches it.
- Drives the memory's read/write enables, address and write data over a fixed number of wait cycles.
- Holds `freeze` high so the upstream pipeline stalls, then returns the registered load result to the WB path.

Parameters:
- WAIT_CYCLES, 4, cycles the memory access occupies (legal range 1..15).
- BASE_ADDR, 1024, byte address of the first data-memory word.
- DEPTH, 64, number of 32-bit words in the data memory.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_r_req  in  1  load request from the EXE/MEM register; held by the pipeline while frozen.
- mem_w_req  in  1  store request from the EXE/MEM register; held while frozen.
- address  in  32  byte address of the access.
- wr_data  in  32  store data.
- freeze  out  1  stall request to the IF/ID/EXE stages and pipeline registers.
- done  out  1  one-cycle pulse: access complete.
- rd_result  out  32  registered load data.
- mem_rd_en  out  1  to data memory, read enable.
- mem_wr_en  out  1  to data memory, write enable.
- mem_addr  out  32  to data memory, word-aligned byte address.
- mem_wdata  out  32  to data memory, store data.
- mem_rdata  in  32  from data memory, combinational read data.
- addr_err  out  1  sticky out-of-range flag (feature only; tied 0 otherwise).

Behaviour:
- Reset is asynchronous, active-low. All state is cleared regardless of phase:
  - state=IDLE, counter=0.
  - freeze, done, mem_rd_en, mem_wr_en = 0.
  - rd_result, mem_addr, mem_wdata = 0.
  - addr_err = 0.
- Reset asserted mid-access aborts the access: no write occurs and no `done` pulse is issued.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If mem_r_req or mem_w_req is high, latch op, {address[31:2],2'b00} into mem_addr, and wr_data into mem_wdata.
  - Set counter=WAIT_CYCLES-1 and go to WAIT.
  - If both requests are high, the store wins and no load is performed.
- WAIT:
  - mem_rd_en=1 for the whole state if op=load.
  - Counter decrements each cycle.
  - When counter==0 (the last WAIT cycle):
    - store: mem_wr_en=1 for exactly this one cycle.
    - load: rd_result <= mem_rdata at the clock edge.
  - Then go to DONE.
- DONE:
  - done=1 for one cycle; go to IDLE.
  - Requests are ignored in this cycle, because the inputs still carry the completed instruction.
- freeze is combinational: (state==IDLE && (mem_r_req||mem_w_req)) || state==WAIT.
  - freeze is low in DONE, so the pipeline advances on that edge.
- Latency, with the request in IDLE at cycle 0:
  - WAIT occupies cycles 1..WAIT_CYCLES.
  - DONE and `done` fall in cycle WAIT_CYCLES+1.
  - freeze is high in cycles 0..WAIT_CYCLES: WAIT_CYCLES+1 stall cycles in total.
- rd_result holds its value until the next load completes; stores do not modify it.
- Back-to-back memory instructions: the second request is seen in IDLE in cycle WAIT_CYCLES+2. There is no overlap.
- mem_addr and mem_wdata stay stable from latch until the next accepted request.
- WAIT_CYCLES=1: a single WAIT cycle; freeze is high for 2 cycles.

Optional Feature:
- Macro MEM_STAGE_RANGE_CHECK_EN.
- Defined:
  - In IDLE, an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH) is flagged.
  - The FSM still runs the full WAIT/DONE sequence, so stall timing is identical.
  - mem_rd_en and mem_wr_en stay 0 for the flagged access.
  - A flagged load returns rd_result=0.
  - addr_err is set and stays 1 until reset.
- Undefined: no range check, every address is passed through, and addr_err is tied to 0.

Test Plan:
- Store with WAIT_CYCLES=4: address=0x404, wr_data=0xDEADBEEF.
  -> freeze high for 5 cycles.
  -> mem_wr_en pulses once in cycle 4 with mem_addr=0x404.
  -> done pulses in cycle 5.
- Load from 0x404 after the store, with memory returning 0xDEADBEEF.
  -> mem_rd_en high in cycles 1-4.
  -> rd_result=0xDEADBEEF from cycle 5, and it holds through a following store.
- Unaligned load at address=0x407 -> mem_addr=0x404.
- mem_r_req and mem_w_req both high -> only a write occurs, mem_rd_en stays 0, and rd_result is unchanged.
- Back-to-back: a load followed immediately by a store.
  -> second access starts in cycle 6.
  -> freeze is low only in cycle 5.
  -> exactly one mem_wr_en pulse.
- rst_n low during WAIT of a store.
  -> immediately freeze=0 and mem_wr_en=0.
  -> no write, no done.
  -> after release, state is IDLE.
- With MEM_STAGE_RANGE_CHECK_EN, a load from 0x300.
  -> no mem_rd_en, rd_result=0, addr_err=1 and sticky.
  -> timing identical to a legal load.
